clk_ctl_gen: RTL
================

Name: clk_ctl_gen

Overview:
- Parametrised successor to the EBOX clock control block. Generates per-channel single-`clk` clock *enables*; it never produces gated or derived clocks.
- Adds the following, all under diagnostic function control:
  - programmable rate prescaler
  - run, single-step, conditional-step and burst modes
  - per-cycle time stretch
  - MBOX stall/response handling
  - per-channel disable mask
  - error stop
- Sits between the diagnostic function decoder and the EBOX datapath sections (CRM/EDP/CTL-style channels).

Parameters:
- NCHAN, 3, number of gated datapath channels (1..BURST_W)
- BURST_W, 8, burst counter width and ld_data width
- RATE_W, 2, rate select width (RATE_W <= BURST_W)
- TIME_W, 2, cycle-stretch select width

Ports:
- clk  in  1  system clock; all logic on posedge
- FPGA_RESET_N  in  1  synchronous active-low reset
- func_valid  in  1  one-cycle diagnostic function strobe
- func_code  in  3  0 STOP, 1 START, 2 SS, 3 COND_SS, 4 BURST, 5 CLR_RESET, 6 SET_RESET, 7 NOP
- ld_valid  in  1  one-cycle register load strobe
- ld_sel  in  2  0 burst count, 1 rate_sel, 2 channel disable mask, 3 err_stop_en
- ld_data  in  BURST_W  load data, right-justified (LSBs used)
- time_sel  in  TIME_W  extra prescaler ticks per EBOX cycle
- mbox_wait  in  1  EBOX waiting on MBOX
- mbox_resp  in  1  MBOX response this cycle
- error_in  in  1  fatal error (parity/FS)
- mr_reset  out  1  master reset register
- running  out  1  state is RUN, STEP or BURST
- ebox_clk_en  out  1  one-clk pulse per completed EBOX cycle
- chan_en  out  NCHAN  ebox_clk_en & ~mask[i]
- ebox_sync  out  1  one-clk pulse at the first tick of each EBOX cycle
- burst_count  out  BURST_W  remaining burst count
- error_stop  out  1  stopped due to error

Behaviour:
- Reset (FPGA_RESET_N=0 at posedge):
  - state IDLE; prescaler, cycle counter, burst_count, rate_sel, mask, err_stop_en = 0.
  - mr_reset = 1. All other outputs 0.
- Prescaler:
  - Counts 0..rate_sel; tick when count == rate_sel, then wraps to 0. rate_sel=0 gives a tick every clk.
  - Runs only while running=1; cleared on entry to IDLE or ERRSTOP.
- EBOX cycle:
  - At the first tick of a cycle, time_sel is latched and ebox_sync pulses.
  - A cycle completes on tick number time_sel+1.
  - At the completing tick, if mbox_wait & ~mbox_resp & ~mr_reset, the cycle stalls. The completion is retried each subsequent tick; ebox_sync is not re-pulsed.
  - On completion, ebox_clk_en and chan_en are registered high for exactly one clk.
- States:
  - IDLE: START -> RUN. SS -> STEP. COND_SS -> STEP only if mbox_wait=0, else ignored. BURST -> BURST only if burst_count != 0, else ignored.
  - RUN: continuous cycles.
  - STEP: one completed cycle, then IDLE.
  - BURST: each completion decrements burst_count; the completion that reaches 0 returns to IDLE. No further enables are issued.
  - ERRSTOP: no enables; error_stop = 1.
  - START, SS, COND_SS and BURST received in any non-IDLE state are ignored.
- STOP (any state):
  - Next state IDLE; error_stop cleared.
  - A partial cycle is abandoned with no enable.
  - burst_count is held, not cleared.
- Error:
  - error_in=1 with err_stop_en=1 while running goes to ERRSTOP next clk.
  - An error in the same clk as a completion suppresses that enable.
  - error_in in IDLE is ignored.
- mr_reset:
  - CLR_RESET sets it to 0; SET_RESET sets it to 1.
  - Independent of state. While 1, it overrides the MBOX stall.
- Loads:
  - Take effect at the next clk.
  - A burst-count load while in BURST is ignored.
  - A rate_sel load takes effect at the next prescaler wrap.
- Simultaneous func_valid and ld_valid: both are applied. The function sees pre-load register values.
- Priority: reset > STOP > error > other functions.
- Latency: START strobe sampled at edge t; RUN from t+1. With rate 0, time 0 and no stall, the first ebox_clk_en is high in cycle t+2 and then every clk.

Test Plan:
- Reset, then START, with rate 0 and time 0 -> ebox_clk_en first at t+2, then continuous; after STOP, no further pulses; mr_reset=1 throughout until CLR_RESET.
- Load rate 2, time_sel 1, START -> ebox_clk_en every 6 clks; ebox_sync 3 clks before each enable.
- Load burst 5, BURST -> exactly 5 ebox_clk_en pulses; burst_count steps 4,3,2,1,0; state IDLE. BURST with count 0 -> no pulses.
- Mask 3'b010, SS -> one pulse on chan_en[0] and chan_en[2]; chan_en[1] stays 0.
- RUN with mbox_wait=1 held for 4 clks, then mbox_resp -> enable delayed until resp; no duplicate ebox_sync. Repeat with mr_reset=1 -> no stall.
- err_stop_en=1, error_in during RUN coincident with a completion -> no enable; error_stop=1; STOP clears it. Repeat with err_stop_en=0 -> run continues.

Source files
------------

// File: rtl/clk_ctl_gen.sv
// clk_ctl_gen: EBOX clock control. Produces single-clk clock *enables* for the
// EBOX datapath channels under diagnostic function control: rate prescaler,
// run / single-step / conditional-step / burst modes, per-cycle stretch,
// MBOX stall handling, channel disable mask and error stop. No derived clocks.
module clk_ctl_gen #(
   parameter int NCHAN   = 3,   // gated datapath channels (1..BURST_W)
   parameter int BURST_W = 8,   // burst counter / load data width
   parameter int RATE_W  = 2,   // prescaler rate select width (<= BURST_W)
   parameter int TIME_W  = 2    // cycle-stretch select width
) (
   input  logic               clk,
   input  logic               FPGA_RESET_N,
   input  logic               func_valid,
   input  logic [2:0]         func_code,
   input  logic               ld_valid,
   input  logic [1:0]         ld_sel,
   input  logic [BURST_W-1:0] ld_data,
   input  logic [TIME_W-1:0]  time_sel,
   input  logic               mbox_wait,
   input  logic               mbox_resp,
   input  logic               error_in,
   output logic               mr_reset,
   output logic               running,
   output logic               ebox_clk_en,
   output logic [NCHAN-1:0]   chan_en,
   output logic               ebox_sync,
   output logic [BURST_W-1:0] burst_count,
   output logic               error_stop
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_STEP,
      S_BURST,
      S_ERRSTOP
   } state_t;

   typedef enum logic [2:0] {
      F_STOP      = 3'd0,
      F_START     = 3'd1,
      F_SS        = 3'd2,
      F_COND_SS   = 3'd3,
      F_BURST     = 3'd4,
      F_CLR_RESET = 3'd5,
      F_SET_RESET = 3'd6,
      F_NOP       = 3'd7
   } func_t;

   typedef enum logic [1:0] {
      L_BURST  = 2'd0,
      L_RATE   = 2'd1,
      L_MASK   = 2'd2,
      L_ERR_EN = 2'd3
   } ld_t;

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   state_t               state_q,     state_d;
   logic [RATE_W-1:0]    presc_q,     presc_d;
   logic [RATE_W-1:0]    rate_pend_q, rate_pend_d;   // last loaded rate_sel
   logic [RATE_W-1:0]    rate_act_q,  rate_act_d;    // rate the prescaler uses
   logic                 in_cyc_q,    in_cyc_d;      // first tick already taken
   logic [TIME_W-1:0]    tcnt_q,      tcnt_d;        // ticks taken this cycle
   logic [TIME_W-1:0]    time_lat_q,  time_lat_d;    // time_sel for this cycle
   logic [BURST_W-1:0]   burst_q,     burst_d;
   logic [NCHAN-1:0]     mask_q,      mask_d;
   logic                 err_en_q,    err_en_d;
   logic                 mr_reset_q,  mr_reset_d;
   logic                 running_q,   running_d;
   logic                 err_stop_q,  err_stop_d;
   logic                 clk_en_q,    clk_en_d;
   logic [NCHAN-1:0]     chan_en_q,   chan_en_d;
   logic                 sync_q,      sync_d;

   // ---------------------------------------------------------------------
   // Decoded strobes and per-clk cycle events
   // ---------------------------------------------------------------------
   logic run_now;    // current state issues EBOX cycles
   logic tick;       // prescaler terminal count this clk
   logic attempt;    // this tick is the completing tick of the cycle
   logic stall;      // completion held off by MBOX
   logic done;       // cycle completes this clk (before suppression)
   logic stop;       // STOP function this clk
   logic err;        // fatal error that stops the clock this clk
   logic fire;       // enable issued this clk
   logic first;      // first tick of a new EBOX cycle
   logic ld_burst, ld_rate, ld_mask, ld_err_en;

   // Decode the current clk's events from registered state and inputs.
   always_comb begin
      run_now   = (state_q == S_RUN) || (state_q == S_STEP) || (state_q == S_BURST);
      tick      = run_now && (presc_q == rate_act_q);
      // A cycle completes on tick number time_sel+1; the first tick of a cycle
      // compares against the live time_sel since nothing is latched yet.
      attempt   = tick && (in_cyc_q ? (tcnt_q == time_lat_q) : (time_sel == '0));
      // mr_reset held high keeps the EBOX moving even if the MBOX looks busy.
      stall     = attempt && mbox_wait && !mbox_resp && !mr_reset_q;
      done      = attempt && !stall;
      stop      = func_valid && (func_t'(func_code) == F_STOP);
      err       = run_now && error_in && err_en_q;
      fire      = done && !stop && !err;
      first     = tick && !in_cyc_q && !stop && !err;
      ld_burst  = ld_valid && (ld_t'(ld_sel) == L_BURST);
      ld_rate   = ld_valid && (ld_t'(ld_sel) == L_RATE);
      ld_mask   = ld_valid && (ld_t'(ld_sel) == L_MASK);
      ld_err_en = ld_valid && (ld_t'(ld_sel) == L_ERR_EN);
   end

   // Next-state logic for the mode FSM and all control registers.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d     = state_q;
      presc_d     = presc_q;
      rate_pend_d = rate_pend_q;
      rate_act_d  = rate_act_q;
      in_cyc_d    = in_cyc_q;
      tcnt_d      = tcnt_q;
      time_lat_d  = time_lat_q;
      burst_d     = burst_q;
      mask_d      = mask_q;
      err_en_d    = err_en_q;
      mr_reset_d  = mr_reset_q;

      // Mode transitions: STOP beats error, error beats other functions.
      if (stop) begin
         state_d = S_IDLE;
      end else if (err) begin
         state_d = S_ERRSTOP;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (func_valid) begin
                  case (func_t'(func_code))
                     F_START:   state_d = S_RUN;
                     F_SS:      state_d = S_STEP;
                     F_COND_SS: if (!mbox_wait) state_d = S_STEP;
                     F_BURST:   if (burst_q != '0) state_d = S_BURST;
                     default:   state_d = S_IDLE;
                  endcase
               end
            end
            S_STEP:  if (fire) state_d = S_IDLE;
            S_BURST: if (fire && (burst_q == BURST_W'(1))) state_d = S_IDLE;
            default: state_d = state_q;
         endcase
      end

      running_d  = (state_d == S_RUN) || (state_d == S_STEP) || (state_d == S_BURST);
      err_stop_d = (state_d == S_ERRSTOP);

      // Master reset register follows its own functions regardless of mode.
      if (func_valid && (func_t'(func_code) == F_CLR_RESET)) mr_reset_d = 1'b0;
      if (func_valid && (func_t'(func_code) == F_SET_RESET)) mr_reset_d = 1'b1;

      // Register loads; the function above already used the pre-load values.
      if (ld_rate)   rate_pend_d = ld_data[RATE_W-1:0];
      if (ld_mask)   mask_d      = ld_data[NCHAN-1:0];
      if (ld_err_en) err_en_d    = ld_data[0];

      // Burst count: decrement per issued burst enable; loads are locked out
      // while a burst is in flight so the count cannot be disturbed.
      if ((state_q == S_BURST) && fire) begin
         burst_d = burst_q - BURST_W'(1);
      end else if (ld_burst && (state_q != S_BURST)) begin
         burst_d = ld_data;
      end

      // A new rate only takes hold when the prescaler is at its wrap point
      // (or idle), so a running count never overshoots the new terminal value.
      if (!run_now || tick) rate_act_d = rate_pend_d;

      // Prescaler and EBOX cycle tracking.
      if (!running_d) begin
         presc_d  = '0;
         in_cyc_d = 1'b0;
         tcnt_d   = '0;
      end else if (run_now) begin
         if (tick) begin
            presc_d = '0;
            if (!in_cyc_q) time_lat_d = time_sel;
            if (done) begin
               in_cyc_d = 1'b0;
               tcnt_d   = '0;
            end else if (stall) begin
               // Hold the tick count so the completion is retried next tick.
               in_cyc_d = 1'b1;
            end else begin
               in_cyc_d = 1'b1;
               tcnt_d   = tcnt_q + TIME_W'(1);
            end
         end else begin
            presc_d = presc_q + RATE_W'(1);
         end
      end

      clk_en_d  = fire;
      chan_en_d = fire ? ~mask_q : '0;
      sync_d    = first;
   end

   // Clock all state and registered outputs; synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge value of every other register.
      if (!FPGA_RESET_N) begin
         state_q     <= S_IDLE;
         presc_q     <= '0;
         rate_pend_q <= '0;
         rate_act_q  <= '0;
         in_cyc_q    <= 1'b0;
         tcnt_q      <= '0;
         time_lat_q  <= '0;
         burst_q     <= '0;
         mask_q      <= '0;
         err_en_q    <= 1'b0;
         mr_reset_q  <= 1'b1;
         running_q   <= 1'b0;
         err_stop_q  <= 1'b0;
         clk_en_q    <= 1'b0;
         chan_en_q   <= '0;
         sync_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         presc_q     <= presc_d;
         rate_pend_q <= rate_pend_d;
         rate_act_q  <= rate_act_d;
         in_cyc_q    <= in_cyc_d;
         tcnt_q      <= tcnt_d;
         time_lat_q  <= time_lat_d;
         burst_q     <= burst_d;
         mask_q      <= mask_d;
         err_en_q    <= err_en_d;
         mr_reset_q  <= mr_reset_d;
         running_q   <= running_d;
         err_stop_q  <= err_stop_d;
         clk_en_q    <= clk_en_d;
         chan_en_q   <= chan_en_d;
         sync_q      <= sync_d;
      end
   end

   assign mr_reset    = mr_reset_q;
   assign running     = running_q;
   assign ebox_clk_en = clk_en_q;
   assign chan_en     = chan_en_q;
   assign ebox_sync   = sync_q;
   assign burst_count = burst_q;
   assign error_stop  = err_stop_q;

endmodule
